// File: rtl/beam_sort_pkg.sv
// Shared types and defaults for the beam-power top-K sorter.
package beam_sort_pkg;

  localparam int unsigned BEAMS_IN_DEF = 64;
  localparam int unsigned BEAM_DEF     = 16;
  localparam int unsigned PWR_W_DEF    = 32;
  localparam int unsigned IDX_W        = 7;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [PWR_W_DEF-1:0] pwr;
    logic [IDX_W-1:0]     idx;
  } entry_t;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_MAX) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/beam_sort_if.sv
// Beam-power sample stream in, selected beam indices and status pulses out.
interface beam_sort_if
  import beam_sort_pkg::*;
#(
  parameter int unsigned BEAM  = BEAM_DEF,
  parameter int unsigned PWR_W = PWR_W_DEF
);

  logic                  i_pwr_vld;
  logic [PWR_W-1:0]      i_pwr_data;
  logic                  i_pwr_sop;
  logic                  i_pwr_eop;
  logic [BEAM-1:0][7:0]  o_beam_idx;
  logic                  o_rbg_load;
  logic                  o_err;

  modport master (
    output i_pwr_vld, i_pwr_data, i_pwr_sop, i_pwr_eop,
    input  o_beam_idx, o_rbg_load, o_err
  );

  modport slave (
    input  i_pwr_vld, i_pwr_data, i_pwr_sop, i_pwr_eop,
    output o_beam_idx, o_rbg_load, o_err
  );

endinterface

// File: rtl/beam_sort_cell.sv
// One slot of the sorted table: holds an entry and decides keep / take sample / shift down.
module beam_sort_cell
  import beam_sort_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   ins_i,
  input  logic   clr_i,
  input  entry_t sample_i,
  input  entry_t upper_i,
  input  logic   upper_disp_i,
  output entry_t entry_o,
  output logic   disp_o
);

  entry_t entry_q, entry_d;
  entry_t own, shift_in;

  // A clear is folded in combinationally so the sop sample lands in an empty table.
  always_comb begin
    own      = clr_i ? '0 : entry_q;
    shift_in = clr_i ? '0 : upper_i;
    disp_o   = !own.valid || (sample_i.pwr > own.pwr);
    entry_d  = entry_q;
    if (ins_i) begin
      if (upper_disp_i)
        entry_d = shift_in;
      else if (disp_o)
        entry_d = sample_i;
      else
        entry_d = own;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      entry_q <= '0;
    else
      entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/beam_sort_top.sv
// Keeps the BEAM strongest beams of each RBG and publishes their indices after eop.
module beam_sort_top
  import beam_sort_pkg::*;
#(
  parameter int unsigned BEAMS_IN = BEAMS_IN_DEF,
  parameter int unsigned BEAM     = BEAM_DEF,
  parameter int unsigned PWR_W    = PWR_W_DEF
) (
  input logic        i_clk,
  input logic        i_reset_n,
  beam_sort_if.slave pwr_if
);

  localparam logic [IDX_W-1:0] CNT_FULL = IDX_W'(BEAMS_IN);
  localparam logic [IDX_W-1:0] CNT_MIN  = IDX_W'(BEAM);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [BEAM-1:0][7:0] idx_q, idx_d;
  logic                 load_q, load_d;
  logic                 err_q, err_d;
  logic                 cnt_err;

  logic                 sop_v, eop_v, ins;
  logic [PWR_W-1:0]     pwr_in;
  entry_t               sample;
  entry_t               tbl      [BEAM];
  entry_t               up_entry [BEAM];
  logic                 up_disp  [BEAM];
  logic                 disp     [BEAM];

  assign sop_v  = pwr_if.i_pwr_vld & pwr_if.i_pwr_sop;
  assign eop_v  = pwr_if.i_pwr_vld & pwr_if.i_pwr_eop;
  assign ins    = pwr_if.i_pwr_vld & (pwr_if.i_pwr_sop | (state_q == ST_FILL));
  assign pwr_in = pwr_if.i_pwr_data;

  assign sample = '{valid: 1'b1,
                    pwr:   PWR_W_DEF'(pwr_in),
                    idx:   sop_v ? '0 : cnt_q};

  for (genvar g = 0; g < BEAM; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign up_entry[g] = '0;
      assign up_disp[g]  = 1'b0;
    end else begin : g_body
      assign up_entry[g] = tbl[g-1];
      assign up_disp[g]  = disp[g-1];
    end

    beam_sort_cell u_cell (
      .clk_i        (i_clk),
      .rst_ni       (i_reset_n),
      .ins_i        (ins),
      .clr_i        (sop_v),
      .sample_i     (sample),
      .upper_i      (up_entry[g]),
      .upper_disp_i (up_disp[g]),
      .entry_o      (tbl[g]),
      .disp_o       (disp[g])
    );
  end

  // In OUT the counter still holds the finished RBG's sample count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    cnt_err = (cnt_q != CNT_FULL) || (cnt_q < CNT_MIN);

    case (state_q)
      ST_IDLE: begin
        if (sop_v)
          state_d = eop_v ? ST_OUT : ST_FILL;
      end
      ST_FILL: begin
        if (eop_v)
          state_d = ST_OUT;
        if (sop_v)
          err_d = 1'b1;
      end
      ST_OUT: begin
        load_d = 1'b1;
        err_d  = cnt_err;
        for (int unsigned i = 0; i < BEAM; i++)
          idx_d[i] = tbl[i].valid ? {1'b0, tbl[i].idx} : 8'd0;
        if (sop_v)
          state_d = eop_v ? ST_OUT : ST_FILL;
        else
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sop_v)
      cnt_d = 7'd1;
    else if (ins)
      cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign pwr_if.o_beam_idx = idx_q;
  assign pwr_if.o_rbg_load = load_q;
  assign pwr_if.o_err      = err_q;

endmodule

// File: doc/beam_sort_top.md
BEAM_SORT_TOP -- requirements
Module: beam_sort_top

Interface
REQ-001 Parameter BEAMS_IN, default 64: number of candidate beams per RBG.
REQ-002 Parameter BEAM, default 16: number of beams selected per RBG.
REQ-003 Parameter PWR_W, default 32: width of the unsigned beam-power word.
REQ-004 i_clk  input  1  single clock; the block shall use one clock only.
REQ-005 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_pwr_vld  input  1  beam-power sample valid.
REQ-007 i_pwr_data  input  PWR_W  unsigned beam power.
REQ-008 i_pwr_sop  input  1  first beam of an RBG; qualified by i_pwr_vld.
REQ-009 i_pwr_eop  input  1  last beam of an RBG; qualified by i_pwr_vld.
REQ-010 o_beam_idx  output  BEAM x 8  selected beam indices; entry 0 is the strongest.
REQ-011 o_rbg_load  output  1  one-cycle pulse when o_beam_idx updates.
REQ-012 o_err  output  1  one-cycle pulse when an RBG has a count error.

Function
REQ-013 Beam index shall be the 0-based sample position within the RBG, taken from a 7-bit counter that clears on sop.
REQ-014 The block shall keep a sorted table of BEAM entries {valid, pwr, idx}, ordered by descending power.
REQ-015 For each valid sample, the block shall compare the sample against all entries in parallel and insert it in one cycle, shifting lower entries down and dropping the last entry.
REQ-016 A sample shall displace an entry only if its power is strictly greater, or the entry is invalid; ties shall keep the lower index.
REQ-017 The table shall accept one sample per cycle with no backpressure.
REQ-018 FSM states: IDLE, FILL, OUT.
- IDLE -> FILL on vld&sop.
- FILL -> OUT on vld&eop.
- OUT -> IDLE after one cycle, or OUT -> FILL if vld&sop occurs in that cycle.
REQ-019 vld&sop shall clear the table and counter, then insert the sample as index 0; this applies in every state.
REQ-020 vld&sop&eop in the same cycle shall form a single-beam RBG.
REQ-021 In OUT, o_beam_idx shall register the table's idx fields, and o_rbg_load shall pulse exactly 2 cycles after the eop sample.
REQ-022 o_beam_idx shall hold its value between o_rbg_load pulses.
REQ-023 Invalid table entries shall output index 8'd0.
REQ-024 o_err shall pulse together with o_rbg_load if the RBG sample count is not BEAMS_IN, or if it is less than BEAM; the indices shall still be output.
REQ-025 A sop arriving in FILL without a prior eop shall discard the partial RBG, start a new one, and pulse o_err the next cycle.
REQ-026 Samples with vld while in IDLE and without sop shall be ignored.
REQ-027 The counter shall saturate at 127; samples after BEAMS_IN within an RBG shall still be sorted and shall set the count error.

Reset
REQ-028 On i_reset_n low, the following shall clear asynchronously: o_beam_idx=0, o_rbg_load=0, o_err=0, FSM=IDLE, all table entries invalid, counter=0.
REQ-029 Reset deasserting mid-RBG shall leave the block in IDLE, waiting for the next sop; no output pulse shall occur.

Structure
REQ-030 A shared package shall hold BEAMS_IN, BEAM, PWR_W defaults, the FSM state enum, and the table-entry struct typedef.
REQ-031 The single compare/insert cell shall be a sub-module named beam_sort_cell, instantiated BEAM times.
- Inputs: sample, upper-neighbour entry, upper-neighbour displace flag.
- Outputs: entry, displace flag.

Verification
REQ-032 64 samples with power = index (0..63), sop/eop framed -> o_rbg_load at eop+2; o_beam_idx = 63,62,...,48; o_err=0.
REQ-033 64 equal powers -> o_beam_idx = 0,1,...,15; o_err=0.
REQ-034 Back-to-back RBGs: sop on the cycle after the previous eop, powers reversed (power = 63-index) -> second load gives 0..15, and the first RBG's load is unaffected.
REQ-035 RBG of 10 samples -> entries 0..9 sorted, entries 10..15 = 0, o_err pulses with o_rbg_load.
REQ-036 sop at sample 30 of an RBG, then a full 64-sample RBG -> o_err pulse one cycle after that sop; a single o_rbg_load carrying only the new RBG's result.
REQ-037 i_reset_n low at sample 40 -> outputs 0 immediately; no o_rbg_load until a new complete sop..eop frame.
